scarv_cop_dispatch: RTL
=======================

# scarv_cop_dispatch

Sequencing controller between the CPU-side coprocessor interface and the XCrypto functional units. It accepts one decoded instruction at a time (class, exception and init flags from the instruction decoder) and runs it to completion. It either issues the instruction to the one functional unit selected by the one-hot class vector, or runs the 16-cycle CPR clear sequence for init. It then returns a single registered response to the CPU. It owns the illegal-class check, the per-instruction timeout and the response handshake.

## Interface
Parameters:
- `NUM_FU`, 9: number of functional-unit classes; equals the decoder class-vector width.
- `TIMEOUT`, 255: maximum cycles spent in EXEC before aborting; range 1..255.

Ports (clock and reset first):
- `g_clk`  in  1  core clock; all state updates on the rising edge.
- `g_reset`  in  1  asynchronous, active-high reset.
- `insn_req`  in  1  CPU presents a decoded instruction.
- `insn_ack`  out  1  instruction accepted this cycle.
- `id_class`  in  NUM_FU  one-hot instruction class.
- `id_exception`  in  1  decoder flagged the instruction illegal.
- `id_cprs_init`  in  1  instruction is init.
- `id_rd`  in  5  GPR destination; echoed in the response.
- `fu_ivalid`  out  NUM_FU  one-hot issue strobe to the selected unit.
- `fu_idone`  in  NUM_FU  per-unit completion pulse.
- `fu_rdata`  in  NUM_FU*32  per-unit GPR result; unit k occupies bits [32k+31:32k].
- `cprs_init_wen`  out  1  CPR clear write enable.
- `cprs_init_addr`  out  4  CPR index being cleared.
- `rsp_valid`  out  1  response available.
- `rsp_ack`  in  1  CPU consumes the response.
- `rsp_status`  out  2  response status: 0 = ok, 1 = illegal, 2 = timeout.
- `rsp_data`  out  32  result from the selected unit; 0 for init, illegal and timeout.
- `rsp_rd`  out  5  latched `id_rd`.

## Operation
- The controller has four states: IDLE, INIT, EXEC and RESP.
- `insn_ack` is driven combinationally and equals `(state==IDLE) & insn_req`.
- On accept, the controller latches `id_class`, `id_rd` and the flags.
- Transitions out of IDLE on accept, in priority order:
  - `id_exception`=1, or `id_class` not exactly one-hot: go to RESP with status 1. `id_cprs_init` is ignored in this case.
  - `id_cprs_init`=1: go to INIT.
  - Otherwise: go to EXEC.
- INIT:
  - `cprs_init_wen`=1 for 16 consecutive cycles.
  - `cprs_init_addr` counts 0..15.
  - After address 15 the controller goes to RESP with status 0 and data 0.
- EXEC:
  - `fu_ivalid` equals the latched class and is held for every EXEC cycle.
  - A 4-bit counter is not sufficient for the timeout; use an 8-bit cycle counter, cleared on entry and incremented each EXEC cycle.
  - If `fu_idone[k]` is asserted for the selected k, the controller captures `fu_rdata` slice k into `rsp_data` and goes to RESP with status 0.
  - `fu_idone` bits for non-selected units are ignored.
  - If the counter reaches TIMEOUT-1 without `fu_idone`, the controller goes to RESP with status 2 and data 0.
  - If `fu_idone` arrives in the same cycle the counter reaches TIMEOUT-1, completion wins and status is 0.
- RESP:
  - `rsp_valid`=1, and `rsp_status`, `rsp_data` and `rsp_rd` are held stable until `rsp_ack`.
  - On `rsp_ack` the controller goes to IDLE.
  - `insn_ack`=0 throughout RESP, so the next instruction is accepted no earlier than the cycle after the ack.
- Response outputs are registers and change only on the entry edge into RESP.

## Timing
- Reset value of every output: `fu_ivalid`=0, `cprs_init_wen`=0, `cprs_init_addr`=0, `rsp_valid`=0, `rsp_status`=0, `rsp_data`=0, `rsp_rd`=0. `insn_ack`=0 because the state resets to IDLE with no request pending.
- Reset asserted mid-operation aborts immediately to IDLE. No completion or response is generated for the aborted instruction, and `fu_ivalid` drops asynchronously.
- Accept in cycle N:
  - `fu_ivalid` is high from N+1.
  - Fastest completion: `fu_idone` at N+1 gives `rsp_valid` at N+2.
  - Illegal instruction: `rsp_valid` at N+1.
  - Init: `cprs_init_wen` is high N+1..N+16 and `rsp_valid` rises at N+17.
  - Timeout: `fu_ivalid` is high for exactly TIMEOUT cycles (N+1..N+TIMEOUT) and `rsp_valid` rises at N+TIMEOUT+1.
- `rsp_ack` in the same cycle `rsp_valid` rises is legal: the controller is in IDLE the next cycle, and a request held high is accepted there.

## Test plan
- ADD-class op, class=9'b000000100, unit 2 asserts `fu_idone` 3 cycles after `fu_ivalid` with data 0xDEADBEEF, rd=7 -> `fu_ivalid` is 9'b000000100 for 3 cycles; response status 0, data 0xDEADBEEF, rd 7; `insn_ack` stays low until the cycle after `rsp_ack`.
- `id_exception`=1 with a valid class, and separately class=9'b000000110 -> `rsp_valid` at N+1 with status 1 and data 0; `fu_ivalid` is never asserted.
- Init accepted at N -> `cprs_init_wen` high N+1..N+16 with addresses 0..15 in order; response status 0 at N+17.
- Selected unit never completes, TIMEOUT=255 -> `fu_ivalid` high for exactly 255 cycles; status 2; a spurious `fu_idone` from another unit during this window is ignored.
- `rsp_ack` withheld for 10 cycles with `insn_req` held high -> response outputs stable, no second accept; the second instruction is accepted the cycle after the ack.
- `g_reset` pulsed during EXEC and during INIT (address 7) -> all outputs 0 immediately; the next instruction completes normally.

Source files
------------

// File: rtl/scarv_cop_dispatch.sv
// Sequences one decoded XCrypto instruction at a time: issue to a functional unit,
// run the CPR clear sequence, or report illegal, then hold a registered response.
module scarv_cop_dispatch #(
    parameter int NUM_FU  = 9,
    parameter int TIMEOUT = 255
) (
    input  logic                 g_clk,
    input  logic                 g_reset,
    input  logic                 insn_req,
    output logic                 insn_ack,
    input  logic [NUM_FU-1:0]    id_class,
    input  logic                 id_exception,
    input  logic                 id_cprs_init,
    input  logic [4:0]           id_rd,
    output logic [NUM_FU-1:0]    fu_ivalid,
    input  logic [NUM_FU-1:0]    fu_idone,
    input  logic [NUM_FU*32-1:0] fu_rdata,
    output logic                 cprs_init_wen,
    output logic [3:0]           cprs_init_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ack,
    output logic [1:0]           rsp_status,
    output logic [31:0]          rsp_data,
    output logic [4:0]           rsp_rd
);

    typedef enum logic [1:0] {IDLE, INIT, EXEC, RESP} state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ILLEGAL = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t             state;
    logic [NUM_FU-1:0]  cls_q;
    logic [4:0]         rd_q;
    logic [7:0]         exec_cnt;
    logic               fu_hit;
    logic [31:0]        fu_sel_data;

    function automatic logic is_onehot(input logic [NUM_FU-1:0] v);
        return (v != '0) && ((v & (v - NUM_FU'(1))) == '0);
    endfunction

    assign insn_ack = (state == IDLE) && insn_req;

    // Completions from units other than the latched class are masked off here.
    always_comb begin
        fu_hit      = |(fu_idone & cls_q);
        fu_sel_data = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (cls_q[k]) begin
                fu_sel_data = fu_sel_data | fu_rdata[32*k +: 32];
            end
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state          <= IDLE;
            cls_q          <= '0;
            rd_q           <= '0;
            exec_cnt       <= '0;
            fu_ivalid      <= '0;
            cprs_init_wen  <= 1'b0;
            cprs_init_addr <= '0;
            rsp_valid      <= 1'b0;
            rsp_status     <= ST_OK;
            rsp_data       <= '0;
            rsp_rd         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (insn_req) begin
                        cls_q <= id_class;
                        rd_q  <= id_rd;
                        if (id_exception || !is_onehot(id_class)) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_status <= ST_ILLEGAL;
                            rsp_data   <= '0;
                            rsp_rd     <= id_rd;
                        end else if (id_cprs_init) begin
                            state          <= INIT;
                            cprs_init_wen  <= 1'b1;
                            cprs_init_addr <= '0;
                        end else begin
                            state     <= EXEC;
                            fu_ivalid <= id_class;
                            exec_cnt  <= '0;
                        end
                    end
                end
                INIT: begin
                    // The address wraps back to 0 as the last entry is cleared.
                    cprs_init_addr <= cprs_init_addr + 4'd1;
                    if (cprs_init_addr == 4'd15) begin
                        state         <= RESP;
                        cprs_init_wen <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_status    <= ST_OK;
                        rsp_data      <= '0;
                        rsp_rd        <= rd_q;
                    end
                end
                EXEC: begin
                    exec_cnt <= exec_cnt + 8'd1;
                    if (fu_hit) begin
                        state      <= RESP;
                        fu_ivalid  <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_OK;
                        rsp_data   <= fu_sel_data;
                        rsp_rd     <= rd_q;
                    end else if (exec_cnt == TIMEOUT_LAST) begin
                        state      <= RESP;
                        fu_ivalid  <= '0;
                        rsp_valid  <= 1'b1;
                        rsp_status <= ST_TIMEOUT;
                        rsp_data   <= '0;
                        rsp_rd     <= rd_q;
                    end
                end
                RESP: begin
                    if (rsp_ack) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
